iq_issue_sched: RTL and testbench
=================================

# iq_issue_sched

Allocation and select scheduler for the 16-entry centralized issue queue of the RV64 out-of-order core. Owns the per-entry valid bits and an age matrix. Hands free entry addresses to the 4-wide dispatch stage and picks the oldest woken-up entries for up to two issue ports with a valid/ready handshake. The issue queue payload array writes its entries at the addresses this block grants.

## Interface
- `IQ_DEPTH`, 16, number of issue queue entries.
- `IDX_W`, 4, entry index width (log2 of `IQ_DEPTH`).
- `DISP_W`, 4, dispatch slots per cycle.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  pipeline flush; invalidates every entry.
- `alloc_req`  in  4  bit i: dispatch slot i needs an entry.
- `alloc_gnt`  out  4  bit i: slot i granted; combinational.
- `alloc_stall`  out  1  request refused for lack of free entries.
- `alloc_addr0`..`alloc_addr3`  out  4 each  entry assigned to slot 0..3; combinational.
- `entry_rdy`  in  16  wakeup result; bit k: all needed sources of entry k are ready.
- `iss0_valid`, `iss1_valid`  out  1  port has a selected entry.
- `iss0_idx`, `iss1_idx`  out  4  selected entry index.
- `iss0_ready`, `iss1_ready`  in  1  execute unit accepts the issue.
- `entry_valid`  out  16  registered occupancy vector.
- `free_cnt`  out  5  number of free entries, 0..16.

## Operation
- Free vector: `~entry_valid`, taken from registered state only. There is no same-cycle reuse of an entry that is being issued.
- Slot assignment: the k-th set bit of `alloc_req` (counted from slot 0) gets the k-th lowest free index. `alloc_addr` for an unrequested slot is don't-care.
- All-or-nothing allocation:
  - If popcount(`alloc_req`) ≤ `free_cnt`, then `alloc_gnt` = `alloc_req` and `alloc_stall` = 0.
  - Otherwise `alloc_gnt` = 0 and `alloc_stall` = (`alloc_req` ≠ 0).
- Age matrix `older[i][j]` = 1 means entry j is older than entry i. On allocating entry i:
  - Row i is set to the current `entry_valid`, OR'd with the entries granted to lower-numbered slots in the same cycle.
  - Column i is cleared.
- Select request: `req[k]` = `entry_valid[k]` & `entry_rdy[k]`.
  - Port 0 takes the k with `req[k]` set and no j such that `req[j]` & `older[k][j]`.
  - Port 1 applies the same rule to `req` with the port-0 pick masked out.
  - At most one candidate exists per port by construction.
- Handshake:
  - An entry is removed (`entry_valid` cleared) on the edge where its port has valid & ready.
  - With valid & !ready the entry stays. Selection is recomputed every cycle, so `iss_idx` may change while ready is low. There is no stability obligation.
- Simultaneous alloc and issue of different entries are both applied in the same edge.
- `flush` has priority over everything:
  - In the flush cycle, `alloc_gnt` = 0, `alloc_stall` = 0, and both `iss*_valid` = 0.
  - Next cycle, `entry_valid` = 0 and the age matrix is cleared.
- `free_cnt` is derived from the registered `entry_valid`.

## Timing
- Reset values: `entry_valid` = 0, age matrix = 0, `free_cnt` = 16, `iss0_valid` = `iss1_valid` = 0, `iss*_idx` = 0, `alloc_gnt` = 0, `alloc_stall` = 0.
- Reset mid-operation drops all entries immediately, with no drain.
- Grant latency is 0 cycles (combinational). An entry granted in cycle N is valid from N+1 and issuable from N+1 if `entry_rdy` is high.
- Issue latency: an entry valid and ready in cycle N can be issued in cycle N if `iss_ready` is high. Its slot becomes free in cycle N+1.
- Full (`free_cnt` = 0): any nonzero `alloc_req` stalls. Empty: both `iss*_valid` = 0.

## Configuration
- `IQ_SCHED_DUAL_ISSUE_EN` defined: ports 0 and 1 are both active, as described above.
- Not defined: `iss1_valid` is tied 0, `iss1_idx` is tied 0, `iss1_ready` is ignored, and only port 0 selects. The port list is unchanged.

## Test plan
- Reset, then `alloc_req`=4'b1111 → `alloc_gnt`=4'b1111, addrs 0,1,2,3. Next cycle `entry_valid`=16'h000F and `free_cnt`=12.
- Fill 14 entries, then `alloc_req`=4'b0111 → `alloc_gnt`=0 and `alloc_stall`=1. Issue 1 entry; next cycle the same request is granted.
- Allocate A (entry 0), then B (entry 1) a cycle later, then C (entry 2); set `entry_rdy`=16'h0006 → port 0 picks 1 (B) and port 1 picks 2 (C). Raise `entry_rdy[0]` → port 0 picks 0.
- Hold `iss0_ready`=0 for 3 cycles with a selected entry → the entry stays valid and `free_cnt` is unchanged. Raise ready → the entry clears on that edge.
- 16 entries valid, `flush` with `alloc_req`=4'b0011 → `alloc_gnt`=0, then `entry_valid`=0 and `free_cnt`=16 next cycle.
- Build without `IQ_SCHED_DUAL_ISSUE_EN`, two entries ready → only port 0 issues and `iss1_valid` stays 0.

Source files
------------

// File: rtl/iq_issue_sched_if.sv
// Allocation and issue bundle between dispatch, issue queue scheduler and execute units.
// Handshake: an issue port transfers on a rising edge where both issN_valid and issN_ready are 1.
interface iq_issue_sched_if #(
   parameter int IQ_DEPTH = 16,
   parameter int IDX_W    = 4,
   parameter int DISP_W   = 4
);
   logic [DISP_W-1:0]   alloc_req;
   logic [DISP_W-1:0]   alloc_gnt;
   logic                alloc_stall;
   logic [IDX_W-1:0]    alloc_addr0;
   logic [IDX_W-1:0]    alloc_addr1;
   logic [IDX_W-1:0]    alloc_addr2;
   logic [IDX_W-1:0]    alloc_addr3;
   logic [IQ_DEPTH-1:0] entry_rdy;
   logic                iss0_valid;
   logic                iss1_valid;
   logic [IDX_W-1:0]    iss0_idx;
   logic [IDX_W-1:0]    iss1_idx;
   logic                iss0_ready;
   logic                iss1_ready;
   logic [IQ_DEPTH-1:0] entry_valid;
   logic [IDX_W:0]      free_cnt;

   modport master (
      output alloc_req, entry_rdy, iss0_ready, iss1_ready,
      input  alloc_gnt, alloc_stall, alloc_addr0, alloc_addr1, alloc_addr2, alloc_addr3,
      input  iss0_valid, iss1_valid, iss0_idx, iss1_idx, entry_valid, free_cnt
   );

   modport slave (
      input  alloc_req, entry_rdy, iss0_ready, iss1_ready,
      output alloc_gnt, alloc_stall, alloc_addr0, alloc_addr1, alloc_addr2, alloc_addr3,
      output iss0_valid, iss1_valid, iss0_idx, iss1_idx, entry_valid, free_cnt
   );
endinterface

// File: rtl/iq_issue_sched.sv
// Issue queue allocation/select scheduler: valid bits, age matrix, 4-wide alloc, oldest-first pick.
// Define IQ_SCHED_DUAL_ISSUE_EN to enable issue port 1; otherwise only port 0 selects.
module iq_issue_sched #(
   parameter int IQ_DEPTH = 16,
   parameter int IDX_W    = 4,
   parameter int DISP_W   = 4
) (
   input logic              clk,
   input logic              rst_n,
   input logic              flush,
   iq_issue_sched_if.slave  bus
);
   logic [IQ_DEPTH-1:0] entry_valid_q;
   logic [IQ_DEPTH-1:0] older_q    [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] older_next [IQ_DEPTH];

   logic [IDX_W-1:0]    addr [DISP_W];
   logic [IDX_W:0]      n_req;
   logic [IDX_W:0]      n_valid;
   logic [IDX_W:0]      free_cnt_w;
   logic                fits;
   logic [DISP_W-1:0]   gnt;
   logic [IQ_DEPTH-1:0] alloc_oh;
   logic [IQ_DEPTH-1:0] req_v, req1, pick0, pick1, fire;
   logic                v0, v1;
   logic [IDX_W-1:0]    idx0, idx1;

   always_comb begin
      n_valid = '0;
      for (int k = 0; k < IQ_DEPTH; k++)
         n_valid = n_valid + {{IDX_W{1'b0}}, entry_valid_q[k]};
      free_cnt_w = (IDX_W+1)'(IQ_DEPTH) - n_valid;
   end

   // Each requesting slot, in slot order, takes the lowest index still free.
   always_comb begin
      logic [IQ_DEPTH-1:0] avail;
      logic                found;
      avail = ~entry_valid_q;
      n_req = '0;
      for (int s = 0; s < DISP_W; s++) begin
         addr[s] = '0;
         found   = 1'b0;
         for (int k = 0; k < IQ_DEPTH; k++) begin
            if (!found && avail[k]) begin
               addr[s] = IDX_W'(k);
               found   = 1'b1;
            end
         end
         if (bus.alloc_req[s]) begin
            avail[addr[s]] = 1'b0;
            n_req          = n_req + (IDX_W+1)'(1);
         end
      end
      fits        = (n_req <= free_cnt_w);
      gnt         = (!flush && fits) ? bus.alloc_req : '0;
      bus.alloc_stall = !flush && !fits && (bus.alloc_req != '0);
   end

   // New entries: clear their column, then load their row with everything already present.
   always_comb begin
      logic [IQ_DEPTH-1:0] prior;
      alloc_oh = '0;
      for (int i = 0; i < IQ_DEPTH; i++)
         older_next[i] = older_q[i];
      for (int s = 0; s < DISP_W; s++)
         if (gnt[s]) alloc_oh[addr[s]] = 1'b1;
      for (int i = 0; i < IQ_DEPTH; i++)
         for (int r = 0; r < IQ_DEPTH; r++)
            if (alloc_oh[i]) older_next[r][i] = 1'b0;
      prior = entry_valid_q;
      for (int s = 0; s < DISP_W; s++) begin
         if (gnt[s]) begin
            older_next[addr[s]] = prior;
            prior[addr[s]]      = 1'b1;
         end
      end
   end

   always_comb begin
      req_v = entry_valid_q & bus.entry_rdy & {IQ_DEPTH{~flush}};
      pick0 = '0;
      for (int k = 0; k < IQ_DEPTH; k++)
         if (req_v[k] && ((req_v & older_q[k]) == '0)) pick0[k] = 1'b1;
      req1  = req_v & ~pick0;
      pick1 = '0;
      for (int k = 0; k < IQ_DEPTH; k++)
         if (req1[k] && ((req1 & older_q[k]) == '0)) pick1[k] = 1'b1;
      idx0 = '0;
      for (int k = 0; k < IQ_DEPTH; k++)
         if (pick0[k]) idx0 = IDX_W'(k);
      v0 = |pick0;
`ifdef IQ_SCHED_DUAL_ISSUE_EN
      idx1 = '0;
      for (int k = 0; k < IQ_DEPTH; k++)
         if (pick1[k]) idx1 = IDX_W'(k);
      v1 = |pick1;
`else
      idx1 = '0;
      v1   = 1'b0;
`endif
      fire = (pick0 & {IQ_DEPTH{v0 & bus.iss0_ready}}) |
             (pick1 & {IQ_DEPTH{v1 & bus.iss1_ready}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_valid_q <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) older_q[i] <= '0;
      end else if (flush) begin
         entry_valid_q <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) older_q[i] <= '0;
      end else begin
         entry_valid_q <= (entry_valid_q & ~fire) | alloc_oh;
         for (int i = 0; i < IQ_DEPTH; i++) older_q[i] <= older_next[i];
      end
   end

   assign bus.alloc_gnt   = gnt;
   assign bus.alloc_addr0 = addr[0];
   assign bus.alloc_addr1 = addr[1];
   assign bus.alloc_addr2 = addr[2];
   assign bus.alloc_addr3 = addr[3];
   assign bus.iss0_valid  = v0;
   assign bus.iss0_idx    = idx0;
   assign bus.iss1_valid  = v1;
   assign bus.iss1_idx    = idx1;
   assign bus.entry_valid = entry_valid_q;
   assign bus.free_cnt    = free_cnt_w;
endmodule

// File: tb/tb_iq_issue_sched.sv
// Scoreboard bench for iq_issue_sched: sequence-number age model, directed scenarios, random traffic.
module tb_iq_issue_sched;
   localparam int EW = 52;
`ifdef IQ_SCHED_DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   iq_issue_sched_if #(.IQ_DEPTH(16), .IDX_W(4), .DISP_W(4)) bus ();

   iq_issue_sched #(.IQ_DEPTH(16), .IDX_W(4), .DISP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   // Reference model: occupancy plus allocation sequence number (smaller = older).
   bit          m_valid [16];
   int unsigned m_seq   [16];
   int unsigned seq_ctr;

   logic [EW-1:0] exp_q [$];
   int vectors;
   int miscompares;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_seq[i]   = 0;
      end
   endtask

   task automatic cycle(input logic [3:0] req, input logic [15:0] rdy,
                        input logic r0, input logic r1, input logic fl);
      logic [3:0]  e_gnt;
      logic        e_stall;
      logic [15:0] e_addr;
      logic        e_v0, e_v1;
      logic [3:0]  e_i0, e_i1;
      logic [15:0] e_ev;
      logic [4:0]  e_fc;
      int freelist [$];
      int nreq, k, b0, b1;
      @(posedge clk);
      #1;
      bus.alloc_req  = req;
      bus.entry_rdy  = rdy;
      bus.iss0_ready = r0;
      bus.iss1_ready = r1;
      flush          = fl;

      e_ev = '0;
      for (int i = 0; i < 16; i++) begin
         e_ev[i] = m_valid[i];
         if (!m_valid[i]) freelist.push_back(i);
      end
      e_fc = 5'(freelist.size());
      nreq = $countones(req);
      e_gnt = '0; e_stall = 1'b0; e_addr = '0;
      if (!fl) begin
         if (nreq <= freelist.size()) begin
            e_gnt = req;
            k = 0;
            for (int s = 0; s < 4; s++) begin
               if (req[s]) begin
                  e_addr[s*4 +: 4] = 4'(freelist[k]);
                  k++;
               end
            end
         end else begin
            e_stall = (req != 4'b0);
         end
      end

      b0 = -1; b1 = -1;
      if (!fl) begin
         for (int i = 0; i < 16; i++)
            if (m_valid[i] && rdy[i] && (b0 < 0 || m_seq[i] < m_seq[b0])) b0 = i;
         if (DUAL)
            for (int i = 0; i < 16; i++)
               if (i != b0 && m_valid[i] && rdy[i] && (b1 < 0 || m_seq[i] < m_seq[b1])) b1 = i;
      end
      e_v0 = (b0 >= 0); e_i0 = e_v0 ? 4'(b0) : 4'd0;
      e_v1 = (b1 >= 0); e_i1 = e_v1 ? 4'(b1) : 4'd0;
      exp_q.push_back({e_gnt, e_stall, e_addr, e_v0, e_i0, e_v1, e_i1, e_ev, e_fc});

      if (fl) begin
         model_clear();
      end else begin
         if (e_v0 && r0) m_valid[b0] = 1'b0;
         if (e_v1 && r1) m_valid[b1] = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (e_gnt[s]) begin
               m_valid[e_addr[s*4 +: 4]] = 1'b1;
               m_seq[e_addr[s*4 +: 4]]   = seq_ctr;
               seq_ctr++;
            end
         end
      end
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #1;
      bus.alloc_req = '0; bus.entry_rdy = '0; bus.iss0_ready = 1'b0; bus.iss1_ready = 1'b0;
      flush = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("reset_entry_valid", 32'(bus.entry_valid), 32'h0);
      chk("reset_free_cnt", 32'(bus.free_cnt), 32'd16);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops one expectation per cycle, sampled mid-cycle.
   initial begin
      logic [EW-1:0] e;
      logic [15:0]   a_addr, mask;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mask = '0;
            for (int s = 0; s < 4; s++) if (e[48+s]) mask[s*4 +: 4] = 4'hf;
            a_addr = {bus.alloc_addr3, bus.alloc_addr2, bus.alloc_addr1, bus.alloc_addr0};
            chk("gnt_stall", 32'({bus.alloc_gnt, bus.alloc_stall}), 32'(e[51:47]));
            chk("alloc_addr", 32'(a_addr & mask), 32'(e[46:31] & mask));
            chk("iss0", 32'({bus.iss0_valid, bus.iss0_valid ? bus.iss0_idx : 4'd0}), 32'(e[30:26]));
            chk("iss1", 32'({bus.iss1_valid, bus.iss1_valid ? bus.iss1_idx : 4'd0}), 32'(e[25:21]));
            chk("entry_valid", 32'(bus.entry_valid), 32'(e[20:5]));
            chk("free_cnt", 32'(bus.free_cnt), 32'(e[4:0]));
         end
      end
   end

   initial begin
      vectors = 0; miscompares = 0; seq_ctr = 0;
      model_clear();
      bus.alloc_req = '0; bus.entry_rdy = '0; bus.iss0_ready = 1'b0; bus.iss1_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state, then a full 4-wide allocation.
      cycle(4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b1111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
      // Fill to 14, refuse 3, issue one, then grant 3.
      cycle(4'b1111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b1111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0011, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0111, 16'hffff, 1'b1, 1'b0, 1'b0);
      cycle(4'b0111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
      // Full flush with a concurrent request.
      cycle(4'b0011, 16'hffff, 1'b1, 1'b1, 1'b1);
      cycle(4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
      // A, B, C in successive cycles, then oldest-first selection.
      cycle(4'b0001, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0001, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0001, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0006, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0007, 1'b0, 1'b0, 1'b0);
      // Back-pressure on port 0 for 3 cycles, then accept.
      repeat (3) cycle(4'b0000, 16'h0001, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0001, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 16'h0006, 1'b1, 1'b1, 1'b0);
      cycle(4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
      // Out-of-index-order ages: free low entries, refill them, issue everything.
      repeat (4) cycle(4'b1111, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 16'h000f, 1'b1, 1'b1, 1'b0);
      cycle(4'b0000, 16'h000f, 1'b1, 1'b1, 1'b0);
      cycle(4'b0011, 16'h0, 1'b0, 1'b0, 1'b0);
      repeat (12) cycle(4'b0000, 16'hffff, 1'b1, 1'b1, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         if (n == 700) mid_reset();
         cycle(4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      end

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
